fifo_burst_reader: RTL and testbench

//  Read-side controller for the synchronous FIFO. On a start pulse it pops burst_len words

---
 rtl/fifo_burst_reader.sv | 151 +++++++++++++++
 tb/tb_fifo_burst_reader.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Pops burst_len words from a 1-cycle-latency FIFO read port onto a valid/ready stream.
// A 2-entry skid buffer sustains 1 word/cycle under backpressure; abort drops buffered and in-flight words.
module fifo_burst_reader #(
  parameter int width    = 16,
  parameter int cnt_bits = 8
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                start,
  input  logic                abort,
  input  logic [cnt_bits-1:0] burst_len,
  input  logic                fifo_empty,
  input  logic [width-1:0]    fifo_data_out,
  output logic                fifo_read,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [width-1:0]    out_data,
  output logic                busy,
  output logic                done,
  output logic [cnt_bits-1:0] sent_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [cnt_bits-1:0] len_q, len_d;
  logic [cnt_bits-1:0] issued_q, issued_d;
  logic [cnt_bits-1:0] sent_q, sent_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          occ_q, occ_d;
  logic [width-1:0]    head_q, head_d;
  logic [width-1:0]    tail_q, tail_d;

  logic pop;
  logic run_abort;
  logic capture;
  logic room;
  logic last_pop;

  always_comb begin
    pop       = (occ_q != 2'd0) && out_ready;
    run_abort = (state_q == RUN) && abort;
    capture   = inflight_q && !run_abort;
    // occ+inflight never exceeds 2, so a pop this cycle always frees the slot a new read will land in
    room      = ((occ_q + {1'b0, inflight_q}) <= 2'd1) || pop;
    fifo_read = (state_q == RUN) && !abort && !fifo_empty && (issued_q < len_q) && room;
    last_pop  = pop && (cnt_bits'(sent_q + 1'b1) == len_q);
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    inflight_d = fifo_read;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = burst_len;
          issued_d = '0;
          sent_d   = '0;
          state_d  = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort || last_pop) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fifo_read) begin
      issued_d = issued_q + 1'b1;
    end
    if (pop) begin
      sent_d = sent_q + 1'b1;
    end

    case ({pop, capture})
      2'b10: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) begin
          head_d = fifo_data_out;
        end else begin
          tail_d = fifo_data_out;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = fifo_data_out;
        end else begin
          head_d = tail_q;
          tail_d = fifo_data_out;
        end
      end
      default: ;
    endcase

    if (run_abort) begin
      occ_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_comb begin
    out_valid  = (occ_q != 2'd0);
    out_data   = out_valid ? head_q : '0;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    sent_count = sent_q;
  end

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_) !(fifo_read && fifo_empty));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_) !(capture && !pop && (occ_q == 2'd2)));

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO with 1-cycle read latency, output scoreboard,
// one task per scenario. Inputs change at posedge+1, outputs are observed at negedge.
module tb_fifo_burst_reader;
  localparam int W  = 16;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          rst_ = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CB-1:0] burst_len = '0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_read;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          done;
  logic [CB-1:0] sent_count;

  int           n_pass = 0;
  int           n_total = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  logic         rd_seen = 1'b0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_dat = '0;

  fifo_burst_reader #(.width(W), .cnt_bits(CB)) dut (
    .clk(clk), .rst_(rst_), .start(start), .abort(abort), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out), .fifo_read(fifo_read),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Rising-edge half: the FIFO model completes a read sampled in the previous cycle.
  task automatic step_pos();
    @(posedge clk);
    #1;
    if (rd_seen) begin
      if (fq.size() > 0) fifo_data_out = fq.pop_front();
      rd_seen = 1'b0;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  // Falling-edge half: sample the read request and score any delivered word.
  task automatic step_neg();
    logic [W-1:0] w;
    @(negedge clk);
    rd_seen = fifo_read && rst_;
    if (!rst_) begin
      hold_v = 1'b0;
    end else begin
      if (fifo_read) begin
        n_total++;
        if (fifo_empty !== 1'b0) $display("FAIL read_while_empty: fifo_empty=%b with fifo_read=1, required 0", fifo_empty);
        else n_pass++;
      end
      if (hold_v) begin
        n_total++;
        if (out_valid !== 1'b1 || out_data !== hold_dat)
          $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, hold_dat);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard: unexpected word %h, required none", out_data);
        end else begin
          w = exp_q.pop_front();
          if (out_data !== w) $display("FAIL scoreboard: got %h, required %h", out_data, w);
          else n_pass++;
        end
      end
      hold_v   = out_valid && !out_ready && !abort;
      hold_dat = out_data;
    end
  endtask

  task automatic load(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_ = 1'b0;
    #2;
    n_total++;
    if ({fifo_read, out_valid, busy, done} !== 4'b0)
      $display("FAIL reset_flags: rd/vld/busy/done=%b, required 0000", {fifo_read, out_valid, busy, done});
    else n_pass++;
    n_total++;
    if (out_data !== '0 || sent_count !== '0)
      $display("FAIL reset_data: out_data=%h sent=%0d, required 0 0", out_data, sent_count);
    else n_pass++;
    repeat (2) begin step_pos(); step_neg(); end
    step_pos();
    rst_ = 1'b1;
    step_neg();
    n_total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL reset_idle: busy=%b vld=%b, required 0 0", busy, out_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    int nrd = 0, first_rd = -1, last_rd = -1;
    int nval = 0, first_v = -1, last_v = -1;
    int ndone = 0, done_c = -1;
    step_pos();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) load(W'(16'hA000 + i));
    start = 1'b1;
    burst_len = 8'd4;
    step_neg();
    for (int c = 1; c <= 12; c++) begin
      step_pos();
      start = 1'b0;
      step_neg();
      if (fifo_read) begin nrd++; if (first_rd < 0) first_rd = c; last_rd = c; end
      if (out_valid) begin nval++; if (first_v < 0) first_v = c; last_v = c; end
      if (done) begin ndone++; done_c = c; end
    end
    n_total++;
    if (nrd != 4 || last_rd - first_rd != 3 || first_rd != 1)
      $display("FAIL basic_reads: n=%0d first=%0d last=%0d, required 4 consecutive from cycle 1", nrd, first_rd, last_rd);
    else n_pass++;
    n_total++;
    if (nval != 4 || last_v - first_v != 3)
      $display("FAIL basic_valid: n=%0d span=%0d, required 4 consecutive", nval, last_v - first_v);
    else n_pass++;
    n_total++;
    if (ndone != 1 || done_c != last_v + 1)
      $display("FAIL basic_done: pulses=%0d at %0d, required 1 at %0d", ndone, done_c, last_v + 1);
    else n_pass++;
    n_total++;
    if (sent_count !== 8'd4 || exp_q.size() != 0)
      $display("FAIL basic_count: sent=%0d left=%0d, required 4 0", sent_count, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int nrd = 0;
    logic seen = 1'b0;
    step_pos();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) load(W'(16'hB000 + i));
    start = 1'b1;
    burst_len = 8'd6;
    step_neg();
    for (int c = 1; c <= 40 && !seen; c++) begin
      step_pos();
      start = 1'b0;
      if (c == 6) out_ready = 1'b1;
      step_neg();
      if (fifo_read && c <= 5) nrd++;
      if (c == 5) begin
        n_total++;
        if (nrd != 2 || out_valid !== 1'b1)
          $display("FAIL bp_stall: reads=%0d vld=%b, required 2 1", nrd, out_valid);
        else n_pass++;
      end
      if (done) seen = 1'b1;
    end
    n_total++;
    if (!seen || sent_count !== 8'd6 || exp_q.size() != 0)
      $display("FAIL bp_complete: done=%b sent=%0d left=%0d, required 1 6 0", seen, sent_count, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_fifo_empty();
    int nrd = 0, ndone = 0;
    step_pos();
    out_ready = 1'b1;
    load(16'hC001);
    load(16'hC002);
    start = 1'b1;
    burst_len = 8'd5;
    step_neg();
    for (int c = 1; c <= 40 && ndone == 0; c++) begin
      step_pos();
      start = 1'b0;
      if (c == 4) for (int i = 3; i <= 5; i++) load(W'(16'hC000 + i));
      step_neg();
      if (fifo_read) nrd++;
      if (done) ndone++;
    end
    n_total++;
    if (ndone != 1 || nrd != 5 || sent_count !== 8'd5 || exp_q.size() != 0)
      $display("FAIL empty_stall: done=%0d reads=%0d sent=%0d left=%0d, required 1 5 5 0",
               ndone, nrd, sent_count, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int nrd = 0;
    step_pos();
    start = 1'b1;
    burst_len = 8'd0;
    step_neg();
    if (fifo_read) nrd++;
    step_pos();
    start = 1'b0;
    step_neg();
    if (fifo_read) nrd++;
    n_total++;
    if (done !== 1'b1 || busy !== 1'b1) $display("FAIL zero_done: done=%b busy=%b, required 1 1", done, busy);
    else n_pass++;
    step_pos();
    step_neg();
    if (fifo_read) nrd++;
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || sent_count !== 8'd0 || nrd != 0)
      $display("FAIL zero_end: done=%b busy=%b sent=%0d reads=%0d, required 0 0 0 0", done, busy, sent_count, nrd);
    else n_pass++;
  endtask

  task automatic test_abort();
    int npop = 0, nrd = 0;
    step_pos();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) load(W'(16'hD000 + i));
    start = 1'b1;
    burst_len = 8'd8;
    step_neg();
    for (int c = 1; c <= 20 && npop < 3; c++) begin
      step_pos();
      start = 1'b0;
      step_neg();
      if (fifo_read) nrd++;
      if (out_valid && out_ready) npop++;
    end
    step_pos();
    out_ready = 1'b0;
    step_neg();
    if (fifo_read) nrd++;
    repeat (2) begin step_pos(); step_neg(); if (fifo_read) nrd++; end
    n_total++;
    if (npop != 3 || nrd != 5 || out_valid !== 1'b1)
      $display("FAIL abort_setup: pops=%0d reads=%0d vld=%b, required 3 5 1", npop, nrd, out_valid);
    else n_pass++;
    step_pos();
    abort = 1'b1;
    step_neg();
    n_total++;
    if (fifo_read !== 1'b0) $display("FAIL abort_noread: fifo_read=%b, required 0", fifo_read);
    else n_pass++;
    step_pos();
    abort = 1'b0;
    step_neg();
    n_total++;
    if (out_valid !== 1'b0 || done !== 1'b1 || sent_count !== 8'd3)
      $display("FAIL abort_done: vld=%b done=%b sent=%0d, required 0 1 3", out_valid, done, sent_count);
    else n_pass++;
    step_pos();
    step_neg();
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || sent_count !== 8'd3)
      $display("FAIL abort_idle: done=%b busy=%b sent=%0d, required 0 0 3", done, busy, sent_count);
    else n_pass++;
    for (int i = 0; i < nrd - npop; i++) void'(exp_q.pop_front());
    n_total++;
    if (fq.size() != 3 || exp_q.size() != 3 || fq[0] !== exp_q[0] || fq[0] !== 16'hD006)
      $display("FAIL abort_leftover: fifo=%0d head=%h, required 3 D006", fq.size(), (fq.size() > 0) ? fq[0] : 16'h0);
    else n_pass++;
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic test_reset_mid();
    step_pos();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) load(W'(16'hE000 + i));
    start = 1'b1;
    burst_len = 8'd4;
    step_neg();
    for (int c = 1; c <= 4; c++) begin
      step_pos();
      start = 1'b0;
      step_neg();
    end
    n_total++;
    if (out_valid !== 1'b1 || busy !== 1'b1) $display("FAIL midrst_pre: vld=%b busy=%b, required 1 1", out_valid, busy);
    else n_pass++;
    step_pos();
    rst_ = 1'b0;
    #1;
    n_total++;
    if ({fifo_read, out_valid, busy, done} !== 4'b0 || out_data !== '0 || sent_count !== '0)
      $display("FAIL midrst_zero: rd/vld/busy/done=%b data=%h sent=%0d, required all 0",
               {fifo_read, out_valid, busy, done}, out_data, sent_count);
    else n_pass++;
    step_neg();
    step_pos();
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    step_neg();
    step_pos();
    rst_ = 1'b1;
    out_ready = 1'b1;
    step_neg();
    n_total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL midrst_idle: busy=%b vld=%b, required 0 0", busy, out_valid);
    else n_pass++;
  endtask

  task automatic test_soak();
    int ndone = 0;
    step_pos();
    for (int i = 0; i < 20; i++) load(W'($urandom()));
    start = 1'b1;
    burst_len = 8'd40;
    step_neg();
    for (int c = 1; c <= 400 && ndone == 0; c++) begin
      step_pos();
      start = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (c == 15) for (int i = 0; i < 20; i++) load(W'($urandom()));
      step_neg();
      if (done) ndone++;
    end
    n_total++;
    if (ndone != 1 || sent_count !== 8'd40 || exp_q.size() != 0 || fq.size() != 0)
      $display("FAIL soak: done=%0d sent=%0d left=%0d fifo=%0d, required 1 40 0 0",
               ndone, sent_count, exp_q.size(), fq.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_fifo_empty();
    test_zero_len();
    test_abort();
    test_reset_mid();
    test_soak();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
